spart_uart: RTL and testbench

- Special-purpose asynchronous receiver/transmitter: 8N1 serial transmitter and receiver behind a 4-register processor bus.
- Bus side: 2-bit address, 8-bit bidirectional data bus, chip select, read/write strobe, plus status flags tbr and rda.
- Serial side: txd/rxd, directly cross-connectable to a second instance.
- A separate bus master (driver) programs the baud divisor and moves bytes; it is not part of this block.

---
 rtl/spart_pkg.sv | 23 ++
 rtl/spart_baud_gen.sv | 41 ++++
 rtl/spart_uart.sv | 251 +++++++++++++++++++++++++
 tb/tb_spart_uart.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// spart_pkg: shared constants and state encodings for the SPART UART.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spart_pkg;

  // Register map seen on the 2-bit processor address bus.
  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DBL    = 2'b10;
  localparam logic [1:0] ADDR_DBH    = 2'b11;

  // Divisor after reset: 38400 baud at 100 MHz with 16x oversampling.
  localparam logic [15:0] DB_RESET = 16'd162;

  // Enable ticks per serial bit; the tick counters are sized for this value.
  localparam int OVERSAMPLE = 16;
  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] TICK_MID  = 4'(OVERSAMPLE / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/spart_baud_gen.sv
// spart_baud_gen: divisor register plus free-running down-counter; 1-cycle enable every DB+1 clocks.
// Latency: divisor writes take effect at the next counter reload.
// Backpressure: none; writes are always accepted.
module spart_baud_gen
  import spart_pkg::*;
#(
  parameter logic [15:0] DB_RESET = spart_pkg::DB_RESET
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       db_lo_we,
  input  logic       db_hi_we,
  input  logic [7:0] wr_dat,
  output logic       baud_en
);

  logic [15:0] db_q, db_d;
  logic [15:0] cnt_q, cnt_d;

  assign baud_en = (cnt_q == 16'd0);

  // Divisor byte writes and counter reload/decrement.
  always_comb begin
    db_d = db_q;
    if (db_lo_we) db_d[7:0]  = wr_dat;
    if (db_hi_we) db_d[15:8] = wr_dat;
    cnt_d = baud_en ? db_q : cnt_q - 16'd1;
  end

  // Divisor and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q  <= DB_RESET;
      cnt_q <= DB_RESET;
    end else begin
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spart_uart.sv
// spart_uart: 8N1 UART behind a 4-register bus; optional overrun flag under SPART_OVERRUN_EN.
// Latency: bus reads combinational, flags update next clock; frames are 10 bit-times.
// Backpressure: tbr=0 ignores transmit writes; unread receive bytes are overwritten.
module spart_uart
  import spart_pkg::*;
#(
  parameter logic [15:0] DB_RESET = spart_pkg::DB_RESET
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);

  logic baud_en;
  logic tx_wr, rx_rd, st_rd;
  logic [7:0] rd_dat;

  // TX state
  tx_state_e  tx_state_q, tx_state_d;
  logic [3:0] tx_tick_q, tx_tick_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       txd_q, txd_d;
  logic       tbr_q, tbr_d;

  // RX state
  rx_state_e  rx_state_q, rx_state_d;
  logic [3:0] rx_tick_q, rx_tick_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic       rxd_s1_q, rxd_s1_d, rxd_s2_q, rxd_s2_d;
  logic [7:0] rbuf_q, rbuf_d;
  logic       rda_q, rda_d;
  logic       byte_done;

  assign tx_wr = iocs && !iorw && (ioaddr == ADDR_DATA);
  assign rx_rd = iocs &&  iorw && (ioaddr == ADDR_DATA);
  assign st_rd = iocs &&  iorw && (ioaddr == ADDR_STATUS);

  assign txd = txd_q;
  assign tbr = tbr_q;
  assign rda = rda_q;

  spart_baud_gen #(.DB_RESET(DB_RESET)) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .db_lo_we(iocs && (ioaddr == ADDR_DBL)),
    .db_hi_we(iocs && (ioaddr == ADDR_DBH)),
    .wr_dat  (databus),
    .baud_en (baud_en)
  );

`ifdef SPART_OVERRUN_EN
  logic ovr_q, ovr_d;

  // Overrun: a byte landed on top of one nobody read; a status read acknowledges it.
  always_comb begin
    ovr_d = (byte_done && rda_q) || (ovr_q && !st_rd);
  end

  // Overrun flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovr_q <= 1'b0;
    else        ovr_q <= ovr_d;
  end

  wire ovr_bit = ovr_q;
`else
  wire ovr_bit = 1'b0;
`endif

  // Read mux; the bus is only driven for data and status reads.
  always_comb begin
    rd_dat = rbuf_q;
    if (st_rd) rd_dat = {5'b0, ovr_bit, tbr_q, rda_q};
  end

  assign databus = (rx_rd || st_rd) ? rd_dat : 8'bz;

  // TX next state: START and DATA/STOP bits each last OVERSAMPLE enables.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tbr_d      = tbr_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_wr && tbr_q) begin
          tx_state_d = TX_START;
          tx_shift_d = databus;
          tx_tick_d  = 4'd0;
          tbr_d      = 1'b0;
        end
      end
      TX_START: begin
        if (baud_en) begin
          if (tx_tick_q == TICK_LAST) begin
            tx_state_d = TX_DATA;
            tx_tick_d  = 4'd0;
            tx_bit_d   = 3'd0;
          end else begin
            tx_tick_d = tx_tick_q + 4'd1;
          end
        end
      end
      TX_DATA: begin
        if (baud_en) begin
          if (tx_tick_q == TICK_LAST) begin
            tx_tick_d  = 4'd0;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
            else                  tx_bit_d   = tx_bit_q + 3'd1;
          end else begin
            tx_tick_d = tx_tick_q + 4'd1;
          end
        end
      end
      TX_STOP: begin
        if (baud_en) begin
          if (tx_tick_q == TICK_LAST) begin
            tx_state_d = TX_IDLE;
            tbr_d      = 1'b1;
          end else begin
            tx_tick_d = tx_tick_q + 4'd1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // txd follows the state being entered so the line changes with the state register.
    case (tx_state_d)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = tx_shift_d[0];
      default:  txd_d = 1'b1;
    endcase
  end

  // TX registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_tick_q  <= 4'd0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'd0;
      txd_q      <= 1'b1;
      tbr_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
      tbr_q      <= tbr_d;
    end
  end

  // RX next state: confirm start at half a bit, then sample each bit centre.
  always_comb begin
    rxd_s1_d   = rxd;
    rxd_s2_d   = rxd_s1_q;
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    byte_done  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rxd_s2_q) begin
          rx_state_d = RX_START;
          rx_tick_d  = 4'd0;
        end
      end
      RX_START: begin
        if (baud_en) begin
          if (rx_tick_q == TICK_MID) begin
            if (rxd_s2_q) begin
              rx_state_d = RX_IDLE;
            end else begin
              rx_state_d = RX_DATA;
              rx_tick_d  = 4'd0;
              rx_bit_d   = 3'd0;
            end
          end else begin
            rx_tick_d = rx_tick_q + 4'd1;
          end
        end
      end
      RX_DATA: begin
        if (baud_en) begin
          if (rx_tick_q == TICK_LAST) begin
            rx_tick_d  = 4'd0;
            rx_shift_d = {rxd_s2_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            else                  rx_bit_d   = rx_bit_q + 3'd1;
          end else begin
            rx_tick_d = rx_tick_q + 4'd1;
          end
        end
      end
      RX_STOP: begin
        if (baud_en) begin
          if (rx_tick_q == TICK_LAST) begin
            rx_state_d = RX_IDLE;
            byte_done  = rxd_s2_q;  // a low stop bit drops the byte
          end else begin
            rx_tick_d = rx_tick_q + 4'd1;
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Receive buffer and rda: a completing byte wins over a same-cycle read.
  always_comb begin
    rbuf_d = byte_done ? rx_shift_q : rbuf_q;
    rda_d  = byte_done || (rda_q && !rx_rd);
  end

  // RX registers, synchronizer and receive buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_tick_q  <= 4'd0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'd0;
      rbuf_q     <= 8'd0;
      rda_q      <= 1'b0;
    end else begin
      rxd_s1_q   <= rxd_s1_d;
      rxd_s2_q   <= rxd_s2_d;
      rx_state_q <= rx_state_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rbuf_q     <= rbuf_d;
      rda_q      <= rda_d;
    end
  end

endmodule

// File: tb/tb_spart_uart.sv
module tb_spart_uart;
  import spart_pkg::*;

  localparam int CAPN = 1400;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iocs = 1'b0;
  logic       iorw = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  logic [7:0] tb_dat = 8'h00;
  logic       tb_drv = 1'b0;
  wire  [7:0] databus;
  logic       rda, tbr, txd, rxd;
  logic       tb_rxd = 1'b1;
  logic       loop = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  logic cap [0:CAPN-1];

  assign databus = tb_drv ? tb_dat : 8'bz;
  assign rxd = loop ? txd : tb_rxd;

  always #5 clk = ~clk;

  spart_uart dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .iocs   (iocs),
    .iorw   (iorw),
    .ioaddr (ioaddr),
    .databus(databus),
    .rda    (rda),
    .tbr    (tbr),
    .txd    (txd),
    .rxd    (rxd)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [1:0] addr, input logic [7:0] dat, input logic rw);
    @(negedge clk);
    iocs = 1'b1; iorw = rw; ioaddr = addr; tb_dat = dat; tb_drv = 1'b1;
    @(negedge clk);
    iocs = 1'b0; iorw = 1'b0; tb_drv = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] addr, output logic [7:0] dat);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b1; ioaddr = addr; tb_drv = 1'b0;
    #1 dat = databus;
    @(negedge clk);
    iocs = 1'b0; iorw = 1'b0;
  endtask

  function automatic int find_lvl(input int from, input logic lvl);
    if (from < 0) return -1;
    for (int i = from; i < CAPN; i++) if (cap[i] === lvl) return i;
    return -1;
  endfunction

  // Samples the ten bit centres of a frame whose start edge is at index f.
  function automatic logic [9:0] decode(input int f);
    logic [9:0] s;
    s = 10'h3ff;
    if (f < 0) return s;
    for (int k = 0; k < 10; k++) begin
      if (f + 32 + 64 * k < CAPN) s[k] = cap[f + 32 + 64 * k];
    end
    return s;
  endfunction

  // Drives one frame on rxd at 64 clocks per bit; a bad stop bit is held low for 48 clocks.
  task automatic send_frame(input logic [7:0] d, input logic stop_ok);
    @(negedge clk);
    tb_rxd = 1'b0;
    repeat (64) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      tb_rxd = d[k];
      repeat (64) @(negedge clk);
    end
    tb_rxd = stop_ok;
    if (stop_ok) begin
      repeat (64) @(negedge clk);
    end else begin
      repeat (48) @(negedge clk);
      tb_rxd = 1'b1;
    end
    repeat (64) @(negedge clk);
  endtask

  initial begin
    logic [7:0] rd;
    int f, r, q, f2;

    // Reset and idle state.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_txd", 16'(txd), 16'h1);
    chk("reset_tbr", 16'(tbr), 16'h1);
    chk("reset_rda", 16'(rda), 16'h0);
    bus_rd(ADDR_STATUS, rd);
    chk("reset_status", 16'(rd), 16'h02);

    // Divisor 3: enable every 4 clocks, 64-clock bit time. Wait out the reset count.
    bus_wr(ADDR_DBL, 8'h03, 1'b1);
    bus_wr(ADDR_DBH, 8'h00, 1'b1);
    repeat (200) @(negedge clk);

    // Loopback of 0x45.
    loop = 1'b1;
    bus_wr(ADDR_DATA, 8'h45, 1'b0);
    chk("tbr_busy", 16'(tbr), 16'h0);
    for (int i = 0; i < 720; i++) begin
      @(negedge clk);
      cap[i] = txd;
    end
    f = find_lvl(0, 1'b0);
    chk("seq_45", 16'(decode(f)), 16'(10'b1010001010));
    r = find_lvl(f, 1'b1);
    q = find_lvl(r, 1'b0);
    chk("bit_width", 16'(q - r), 16'd64);
    chk("rda_set_45", 16'(rda), 16'h1);
    chk("tbr_done_45", 16'(tbr), 16'h1);
    bus_rd(ADDR_DATA, rd);
    chk("rdata_45", 16'(rd), 16'h45);
    chk("rda_clear", 16'(rda), 16'h0);
    bus_rd(ADDR_STATUS, rd);
    chk("status_idle", 16'(rd), 16'h02);

    // Held write: first frame 0x5A intact, data changed mid-frame, reload only after STOP.
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b0; ioaddr = ADDR_DATA; tb_dat = 8'h5A; tb_drv = 1'b1;
    for (int i = 0; i < CAPN; i++) begin
      @(negedge clk);
      cap[i] = txd;
      if (i == 3) tb_dat = 8'h0F;
      if (i == 700) begin
        iocs = 1'b0; tb_drv = 1'b0;
      end
    end
    f = find_lvl(0, 1'b0);
    chk("seq_5a", 16'(decode(f)), 16'(10'b1010110100));
    r = (f < 0) ? -1 : find_lvl(f + 32 + 64 * 8, 1'b1);
    f2 = find_lvl(r, 1'b0);
    chk("stop_width", 16'(f2 - r), 16'd65);
    chk("seq_0f", 16'(decode(f2)), 16'(10'b1000011110));

    // Two bytes without a read: second byte kept.
    bus_rd(ADDR_STATUS, rd);
`ifdef SPART_OVERRUN_EN
    chk("status_ovr", 16'(rd), 16'h07);
`else
    chk("status_ovr", 16'(rd), 16'h03);
`endif
    bus_rd(ADDR_STATUS, rd);
    chk("status_again", 16'(rd), 16'h03);
    bus_rd(ADDR_DATA, rd);
    chk("rdata_0f", 16'(rd), 16'h0F);

    // Short glitch on rxd: false start.
    loop = 1'b0;
    tb_rxd = 1'b1;
    repeat (10) @(negedge clk);
    tb_rxd = 1'b0;
    repeat (10) @(negedge clk);
    tb_rxd = 1'b1;
    repeat (700) @(negedge clk);
    chk("glitch_rda", 16'(rda), 16'h0);
    bus_rd(ADDR_STATUS, rd);
    chk("glitch_status", 16'(rd), 16'h02);

    // Framing error: stop bit low.
    send_frame(8'h3C, 1'b0);
    repeat (100) @(negedge clk);
    chk("frame_err_rda", 16'(rda), 16'h0);

    // Well-formed externally driven frame.
    send_frame(8'h3C, 1'b1);
    chk("ext_rda", 16'(rda), 16'h1);
    bus_rd(ADDR_DATA, rd);
    chk("ext_rdata", 16'(rd), 16'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
